// File: rtl/id_decode_pipe_if.sv
// Bundle between the IF/ID side, the writeback/hazard sources and the decode stage.
// The decode stage connects through the slave modport.
interface id_decode_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
);
    logic              freeze;
    logic              flush;
    logic [DATA_W-1:0] pc_in;
    logic [31:0]       instr_in;
    logic [3:0]        status_in;
    logic              wb_en;
    logic [REG_AW-1:0] wb_dest;
    logic [DATA_W-1:0] wb_value;
    logic              exe_wb_en;
    logic              exe_mem_r;
    logic [REG_AW-1:0] exe_dest;
    logic              mem_wb_en;
    logic [REG_AW-1:0] mem_dest;

    logic              hazard;
    logic [DATA_W-1:0] ex_pc;
    logic [3:0]        ex_cmd;
    logic              ex_mem_r;
    logic              ex_mem_w;
    logic              ex_wb_en;
    logic              ex_b;
    logic              ex_s;
    logic              ex_imm;
    logic [DATA_W-1:0] ex_val_rn;
    logic [DATA_W-1:0] ex_val_rm;
    logic [11:0]       ex_shift_op;
    logic [23:0]       ex_imm24;
    logic [REG_AW-1:0] ex_dest;
    logic [REG_AW-1:0] ex_src1;
    logic [REG_AW-1:0] ex_src2;

    modport master (
        output freeze, flush, pc_in, instr_in, status_in,
        output wb_en, wb_dest, wb_value,
        output exe_wb_en, exe_mem_r, exe_dest, mem_wb_en, mem_dest,
        input  hazard, ex_pc, ex_cmd, ex_mem_r, ex_mem_w, ex_wb_en, ex_b, ex_s, ex_imm,
        input  ex_val_rn, ex_val_rm, ex_shift_op, ex_imm24, ex_dest, ex_src1, ex_src2
    );

    modport slave (
        input  freeze, flush, pc_in, instr_in, status_in,
        input  wb_en, wb_dest, wb_value,
        input  exe_wb_en, exe_mem_r, exe_dest, mem_wb_en, mem_dest,
        output hazard, ex_pc, ex_cmd, ex_mem_r, ex_mem_w, ex_wb_en, ex_b, ex_s, ex_imm,
        output ex_val_rn, ex_val_rm, ex_shift_op, ex_imm24, ex_dest, ex_src1, ex_src2
    );
endinterface

// File: rtl/id_decode_pipe.sv
// ARM decode stage: register file with write-through, control decode, condition check,
// load-use hazard detection and the ID/EX pipeline register (held on freeze).
module id_decode_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter bit FWD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    id_decode_pipe_if.slave  dec_if
);
    localparam int REG_CNT = 2 ** REG_AW;

    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_TST = 4'b1000;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [3:0]        cmd;
        logic              mem_r;
        logic              mem_w;
        logic              wb_en;
        logic              b;
        logic              s;
        logic              imm;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic [11:0]       shift_op;
        logic [23:0]       imm24;
        logic [REG_AW-1:0] dest;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
    } idex_t;

    // NZCV = status[3:0]; cond 1111 is treated as never.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !c || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    logic [DATA_W-1:0] rf_q [REG_CNT];

    logic [3:0]        cond;
    logic [1:0]        mode;
    logic              imm_bit;
    logic [3:0]        opcode;
    logic              s_bit;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rm;
    logic              is_store;
    logic [REG_AW-1:0] src2;
    logic [DATA_W-1:0] rn_val;
    logic [DATA_W-1:0] src2_val;

    assign cond     = dec_if.instr_in[31:28];
    assign mode     = dec_if.instr_in[27:26];
    assign imm_bit  = dec_if.instr_in[25];
    assign opcode   = dec_if.instr_in[24:21];
    assign s_bit    = dec_if.instr_in[20];
    assign rn       = REG_AW'(dec_if.instr_in[19:16]);
    assign rd       = REG_AW'(dec_if.instr_in[15:12]);
    assign rm       = REG_AW'(dec_if.instr_in[3:0]);
    assign is_store = (mode == 2'b01) && !s_bit;
    assign src2     = is_store ? rd : rm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                rf_q[i] <= '0;
            end
        end else if (dec_if.wb_en) begin
            rf_q[dec_if.wb_dest] <= dec_if.wb_value;
        end
    end

    // Same-cycle writeback is bypassed so WB and ID can overlap without a stall.
    assign rn_val   = (dec_if.wb_en && dec_if.wb_dest == rn)   ? dec_if.wb_value : rf_q[rn];
    assign src2_val = (dec_if.wb_en && dec_if.wb_dest == src2) ? dec_if.wb_value : rf_q[src2];

    logic [3:0] cmd_c;
    logic       wb_c;
    logic       mem_r_c;
    logic       mem_w_c;
    logic       b_c;
    logic       s_c;
    logic       valid_c;

    always_comb begin
        cmd_c   = 4'b0000;
        wb_c    = 1'b0;
        mem_r_c = 1'b0;
        mem_w_c = 1'b0;
        b_c     = 1'b0;
        s_c     = 1'b0;
        valid_c = 1'b0;
        case (mode)
            2'b00: begin
                valid_c = 1'b1;
                wb_c    = 1'b1;
                s_c     = s_bit;
                case (opcode)
                    OP_MOV: cmd_c = 4'b0001;
                    OP_MVN: cmd_c = 4'b1001;
                    OP_ADD: cmd_c = 4'b0010;
                    OP_ADC: cmd_c = 4'b0011;
                    OP_SUB: cmd_c = 4'b0100;
                    OP_SBC: cmd_c = 4'b0101;
                    OP_AND: cmd_c = 4'b0110;
                    OP_ORR: cmd_c = 4'b0111;
                    OP_EOR: cmd_c = 4'b1000;
                    OP_CMP: begin
                        cmd_c = 4'b0100;
                        wb_c  = 1'b0;
                        s_c   = 1'b1;
                    end
                    OP_TST: begin
                        cmd_c = 4'b0110;
                        wb_c  = 1'b0;
                        s_c   = 1'b1;
                    end
                    default: begin
                        valid_c = 1'b0;
                        wb_c    = 1'b0;
                        s_c     = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                valid_c = 1'b1;
                cmd_c   = 4'b0010;
                if (s_bit) begin
                    mem_r_c = 1'b1;
                    wb_c    = 1'b1;
                end else begin
                    mem_w_c = 1'b1;
                end
            end
            2'b10: begin
                valid_c = 1'b1;
                b_c     = 1'b1;
            end
            default: valid_c = 1'b0;
        endcase
    end

    logic ctrl_en;
    logic uses_rn;
    logic uses_rm;
    logic exe_hit;
    logic mem_hit;
    logic raw_hit;
    logic hazard_c;

    assign ctrl_en = valid_c && cond_pass(cond, dec_if.status_in);
    assign uses_rn = !((mode == 2'b00) && (opcode == OP_MOV || opcode == OP_MVN))
                     && (mode != 2'b10);
    assign uses_rm = ((mode == 2'b00) && !imm_bit) || is_store;

    assign exe_hit = (uses_rn && dec_if.exe_dest == rn) || (uses_rm && dec_if.exe_dest == src2);
    assign mem_hit = (uses_rn && dec_if.mem_dest == rn) || (uses_rm && dec_if.mem_dest == src2);

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign raw_hit = FWD_EN ? (dec_if.exe_wb_en && dec_if.exe_mem_r && exe_hit)
                            : ((dec_if.exe_wb_en && exe_hit) || (dec_if.mem_wb_en && mem_hit));
    assign hazard_c = ctrl_en && raw_hit;

    assign dec_if.hazard = hazard_c && rst;

    idex_t dec_c;

    always_comb begin
        dec_c          = '0;
        dec_c.pc       = dec_if.pc_in;
        dec_c.cmd      = ctrl_en ? cmd_c : 4'b0000;
        dec_c.mem_r    = ctrl_en && mem_r_c;
        dec_c.mem_w    = ctrl_en && mem_w_c;
        dec_c.wb_en    = ctrl_en && wb_c;
        dec_c.b        = ctrl_en && b_c;
        dec_c.s        = ctrl_en && s_c;
        dec_c.imm      = ctrl_en && imm_bit && !mode[1];
        dec_c.val_rn   = rn_val;
        dec_c.val_rm   = src2_val;
        dec_c.shift_op = dec_if.instr_in[11:0];
        dec_c.imm24    = dec_if.instr_in[23:0];
        dec_c.dest     = rd;
        dec_c.src1     = rn;
        dec_c.src2     = src2;
    end

    // ID/EX boundary: freeze holds, then flush/hazard insert a bubble.
    idex_t idex_q;
    idex_t idex_d;

    always_comb begin
        idex_d = idex_q;
        if (!dec_if.freeze) begin
            if (dec_if.flush || hazard_c) begin
                idex_d = '0;
            end else begin
                idex_d = dec_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign dec_if.ex_pc       = idex_q.pc;
    assign dec_if.ex_cmd      = idex_q.cmd;
    assign dec_if.ex_mem_r    = idex_q.mem_r;
    assign dec_if.ex_mem_w    = idex_q.mem_w;
    assign dec_if.ex_wb_en    = idex_q.wb_en;
    assign dec_if.ex_b        = idex_q.b;
    assign dec_if.ex_s        = idex_q.s;
    assign dec_if.ex_imm      = idex_q.imm;
    assign dec_if.ex_val_rn   = idex_q.val_rn;
    assign dec_if.ex_val_rm   = idex_q.val_rm;
    assign dec_if.ex_shift_op = idex_q.shift_op;
    assign dec_if.ex_imm24    = idex_q.imm24;
    assign dec_if.ex_dest     = idex_q.dest;
    assign dec_if.ex_src1     = idex_q.src1;
    assign dec_if.ex_src2     = idex_q.src2;
endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed bench for id_decode_pipe: one instance with load-use-only stalling and one
// without forwarding, both fed the same stimulus.
module tb_id_decode_pipe;
    localparam logic [31:0] NOP = 32'hF000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    id_decode_pipe_if #(.DATA_W(32), .REG_AW(4)) bus1 ();
    id_decode_pipe_if #(.DATA_W(32), .REG_AW(4)) bus0 ();

    id_decode_pipe #(.DATA_W(32), .REG_AW(4), .FWD_EN(1'b1)) u_dut_fwd (
        .clk(clk), .rst(rst), .dec_if(bus1.slave));
    id_decode_pipe #(.DATA_W(32), .REG_AW(4), .FWD_EN(1'b0)) u_dut_nofwd (
        .clk(clk), .rst(rst), .dec_if(bus0.slave));

    assign bus0.freeze    = bus1.freeze;
    assign bus0.flush     = bus1.flush;
    assign bus0.pc_in     = bus1.pc_in;
    assign bus0.instr_in  = bus1.instr_in;
    assign bus0.status_in = bus1.status_in;
    assign bus0.wb_en     = bus1.wb_en;
    assign bus0.wb_dest   = bus1.wb_dest;
    assign bus0.wb_value  = bus1.wb_value;
    assign bus0.exe_wb_en = bus1.exe_wb_en;
    assign bus0.exe_mem_r = bus1.exe_mem_r;
    assign bus0.exe_dest  = bus1.exe_dest;
    assign bus0.mem_wb_en = bus1.mem_wb_en;
    assign bus0.mem_dest  = bus1.mem_dest;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b0;
        bus1.freeze    = 1'b0;
        bus1.flush     = 1'b0;
        bus1.pc_in     = 32'h0;
        bus1.instr_in  = NOP;
        bus1.status_in = 4'b0000;
        bus1.wb_en     = 1'b0;
        bus1.wb_dest   = 4'd0;
        bus1.wb_value  = 32'h0;
        bus1.exe_wb_en = 1'b0;
        bus1.exe_mem_r = 1'b0;
        bus1.exe_dest  = 4'd0;
        bus1.mem_wb_en = 1'b0;
        bus1.mem_dest  = 4'd0;
        #3;
        check("rst_ex_pc", bus1.ex_pc, 32'h0);
        check("rst_ex_wb_en", 32'(bus1.ex_wb_en), 32'h0);
        check("rst_hazard", 32'(bus1.hazard), 32'h0);
        tick();
        rst = 1'b1;

        // Preload R2, then ADD R3,R1,R2 with R1 written in the same cycle
        bus1.wb_en = 1'b1; bus1.wb_dest = 4'd2; bus1.wb_value = 32'h22;
        tick();
        bus1.wb_dest = 4'd1; bus1.wb_value = 32'h11;
        bus1.instr_in = 32'hE081_3002; bus1.pc_in = 32'h104;
        tick();
        bus1.wb_en = 1'b0; bus1.instr_in = NOP;
        check("wt_val_rn", bus1.ex_val_rn, 32'h11);
        check("wt_val_rm", bus1.ex_val_rm, 32'h22);
        check("wt_cmd", 32'(bus1.ex_cmd), 32'h2);
        check("wt_wb_en", 32'(bus1.ex_wb_en), 32'h1);
        check("wt_dest", 32'(bus1.ex_dest), 32'h3);
        check("wt_src2", 32'(bus1.ex_src2), 32'h2);
        check("wt_pc", bus1.ex_pc, 32'h104);

        // Load-use against ADD R5,R4,R2
        bus1.exe_wb_en = 1'b1; bus1.exe_mem_r = 1'b1; bus1.exe_dest = 4'd4;
        bus1.instr_in = 32'hE084_5002;
        #1;
        check("lu_hazard_fwd", 32'(bus1.hazard), 32'h1);
        check("lu_hazard_nofwd", 32'(bus0.hazard), 32'h1);
        tick();
        check("lu_bubble_wb", 32'(bus1.ex_wb_en), 32'h0);
        check("lu_bubble_cmd", 32'(bus1.ex_cmd), 32'h0);
        bus1.exe_mem_r = 1'b0;
        #1;
        check("alu_hazard_fwd", 32'(bus1.hazard), 32'h0);
        check("alu_hazard_nofwd", 32'(bus0.hazard), 32'h1);
        tick();
        check("alu_wb_en", 32'(bus1.ex_wb_en), 32'h1);
        check("alu_dest", 32'(bus1.ex_dest), 32'h5);
        bus1.exe_wb_en = 1'b0; bus1.mem_wb_en = 1'b1; bus1.mem_dest = 4'd2;
        #1;
        check("mem_hazard_nofwd", 32'(bus0.hazard), 32'h1);
        check("mem_hazard_fwd", 32'(bus1.hazard), 32'h0);
        bus1.mem_wb_en = 1'b0; bus1.mem_dest = 4'd0; bus1.exe_dest = 4'd0;

        // LDR R4,[R1,#8] then STR R4,[R1,#8]
        bus1.instr_in = 32'hE591_4008;
        tick();
        check("ldr_mem_r", 32'(bus1.ex_mem_r), 32'h1);
        check("ldr_wb_en", 32'(bus1.ex_wb_en), 32'h1);
        check("ldr_cmd", 32'(bus1.ex_cmd), 32'h2);
        check("ldr_shift_op", 32'(bus1.ex_shift_op), 32'h008);
        check("ldr_val_rn", bus1.ex_val_rn, 32'h11);
        bus1.instr_in = 32'hE581_4008;
        tick();
        check("str_src2", 32'(bus1.ex_src2), 32'h4);
        check("str_mem_w", 32'(bus1.ex_mem_w), 32'h1);
        check("str_wb_en", 32'(bus1.ex_wb_en), 32'h0);

        // MOVEQ R0,#1 with Z clear, then Z set
        bus1.instr_in = 32'h03A0_0001; bus1.status_in = 4'b0000;
        tick();
        check("moveq_f_wb", 32'(bus1.ex_wb_en), 32'h0);
        check("moveq_f_cmd", 32'(bus1.ex_cmd), 32'h0);
        bus1.status_in = 4'b0100;
        tick();
        check("moveq_t_cmd", 32'(bus1.ex_cmd), 32'h1);
        check("moveq_t_imm", 32'(bus1.ex_imm), 32'h1);
        check("moveq_t_wb", 32'(bus1.ex_wb_en), 32'h1);
        check("moveq_t_imm24", 32'(bus1.ex_imm24), 32'hA00001);

        // Freeze beats flush; then flush alone bubbles
        bus1.freeze = 1'b1; bus1.flush = 1'b1;
        bus1.instr_in = 32'hE081_3002; bus1.pc_in = 32'h200;
        tick();
        check("frz_cmd", 32'(bus1.ex_cmd), 32'h1);
        check("frz_wb", 32'(bus1.ex_wb_en), 32'h1);
        check("frz_pc", bus1.ex_pc, 32'h104);
        bus1.freeze = 1'b0;
        tick();
        check("fl_wb", 32'(bus1.ex_wb_en), 32'h0);
        check("fl_cmd", 32'(bus1.ex_cmd), 32'h0);
        bus1.flush = 1'b0;

        // CMP R1,R2 with S=0 still sets s; mode 11 is a bubble
        bus1.instr_in = 32'hE141_0002;
        tick();
        check("cmp_cmd", 32'(bus1.ex_cmd), 32'h4);
        check("cmp_s", 32'(bus1.ex_s), 32'h1);
        check("cmp_wb", 32'(bus1.ex_wb_en), 32'h0);
        bus1.instr_in = 32'hEA00_0010;
        tick();
        check("b_b", 32'(bus1.ex_b), 32'h1);
        check("b_wb", 32'(bus1.ex_wb_en), 32'h0);
        bus1.instr_in = 32'hEC10_0000;
        tick();
        check("m11_wb", 32'(bus1.ex_wb_en), 32'h0);
        check("m11_mem_r", 32'(bus1.ex_mem_r), 32'h0);

        // Fill every register, read one back
        bus1.instr_in = NOP;
        for (int i = 0; i < 16; i++) begin
            bus1.wb_en = 1'b1; bus1.wb_dest = 4'(i); bus1.wb_value = 32'h100 + 32'(i);
            tick();
        end
        bus1.wb_en = 1'b0;
        bus1.instr_in = 32'hE087_0007;
        tick();
        check("rf_r7", bus1.ex_val_rn, 32'h107);

        // Asynchronous reset with a pending load-use hazard
        bus1.exe_wb_en = 1'b1; bus1.exe_mem_r = 1'b1; bus1.exe_dest = 4'd7;
        #1;
        check("pre_rst_hazard", 32'(bus1.hazard), 32'h1);
        rst = 1'b0;
        #1;
        check("arst_wb", 32'(bus1.ex_wb_en), 32'h0);
        check("arst_val_rn", bus1.ex_val_rn, 32'h0);
        check("arst_pc", bus1.ex_pc, 32'h0);
        check("arst_hazard_fwd", 32'(bus1.hazard), 32'h0);
        check("arst_hazard_nofwd", 32'(bus0.hazard), 32'h0);
        tick();
        check("arst_hold_wb", 32'(bus1.ex_wb_en), 32'h0);
        rst = 1'b1;
        bus1.exe_wb_en = 1'b0; bus1.exe_mem_r = 1'b0; bus1.exe_dest = 4'd0;
        for (int i = 0; i < 16; i++) begin
            bus1.instr_in = 32'hE080_0000 | (32'(i) << 16) | 32'(i);
            tick();
            check($sformatf("clr_rn_r%0d", i), bus1.ex_val_rn, 32'h0);
            check($sformatf("clr_rm_r%0d", i), bus1.ex_val_rm, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/id_decode_pipe.md
Name: id_decode_pipe

Overview:
Parametrised ARM decode stage. It contains the register file, the control decode, condition evaluation and load-use hazard detection, and it registers the ID/EX pipeline boundary. It sits between the IF/ID register and the EXE stage. It adds write-through bypass, a stall/bubble mechanism, configurable forwarding awareness, and an internal ID/EX register that is held on freeze.

Parameters:
DATA_W, 32, register/operand width
REG_AW, 4, register address width (REG_CNT = 2**REG_AW)
FWD_EN, 1, 1: stall only on load-use; 0: stall on any RAW against EXE or MEM

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
freeze  in  1  downstream stall: hold ID/EX register contents
flush  in  1  branch taken: load a bubble into ID/EX
pc_in  in  DATA_W  PC+4 from IF/ID
instr_in  in  32  instruction from IF/ID
status_in  in  4  NZCV from status register
wb_en  in  1  writeback enable
wb_dest  in  REG_AW  writeback register
wb_value  in  DATA_W  writeback data
exe_wb_en, exe_mem_r  in  1 each  EXE-stage in-flight control
exe_dest  in  REG_AW  EXE-stage destination
mem_wb_en  in  1  MEM-stage writeback enable
mem_dest  in  REG_AW  MEM-stage destination
hazard  out  1  combinational; freeze PC and IF/ID
ex_pc  out  DATA_W  registered PC
ex_cmd  out  4  ALU command
ex_mem_r, ex_mem_w, ex_wb_en, ex_b, ex_s, ex_imm  out  1 each  registered control
ex_val_rn, ex_val_rm  out  DATA_W  operand values
ex_shift_op  out  12  instr[11:0]
ex_imm24  out  24  instr[23:0]
ex_dest, ex_src1, ex_src2  out  REG_AW  register IDs for forwarding

Behaviour:
- Register file: REG_CNT x DATA_W. Written on posedge clk when wb_en. Read combinationally. If wb_en and wb_dest equals the read address, the read returns wb_value (write-through). rst low clears all entries to 0.
- Fields: cond=[31:28], mode=[27:26], I=[25], opcode=[24:21], S/L=[20], Rn=[19:16], Rd=[15:12], Rm=[3:0].
- src1=Rn. src2=Rd when the instruction is a store (mode 01, L=0); otherwise src2=Rm.
- Mode 00 cmd (opcode->cmd): MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110.
- Mode 00 control: wb_en=1 except CMP/TST. s=S, and CMP/TST force s=1. Any other opcode produces a bubble.
- Mode 01: cmd=0010. L=1 gives mem_r=1 and wb_en=1. L=0 gives mem_w=1.
- Mode 10: b=1; all other control 0.
- Mode 11 produces a bubble.
- Condition: standard ARM EQ..AL over status_in. cond=1111 counts as false. If the condition is false, all control bits load as 0 (bubble); no stall results from this.
- Source usage: uses_rn = not (MOV/MVN/branch). uses_rm = (mode 00 and I=0) or store.
- Hazard when the current instruction is valid and a used source matches a stage destination:
  - FWD_EN=1: hazard = exe_wb_en and exe_mem_r and (exe_dest matches a used source).
  - FWD_EN=0: hazard = (exe_wb_en and exe_dest match) or (mem_wb_en and mem_dest match).
- ID/EX update priority on each posedge:
  1. rst low (async): all outputs 0.
  2. freeze: hold all registered outputs.
  3. flush: bubble (all control bits 0; data fields don't-care, driven 0).
  4. hazard: bubble.
  5. Otherwise: load the decoded values.
- The hazard output is asserted independent of freeze/flush. Bubbles never assert wb_en, mem_r, mem_w, b or s.
- Latency: one cycle from instr_in to ex_* outputs.
- Reset mid-operation: registered outputs clear immediately on rst falling edge and stay 0 until the first posedge after rst returns high.

Test Plan:
- Reset: drive rst low mid-run -> all ex_* outputs and hazard 0 with no clock edge; R0..R15 then read 0.
- Write-through: wb_en=1, wb_dest=1, wb_value=0x11 in the same cycle as instr 0xE0813002 (ADD R3,R1,R2), with R2 preloaded to 0x22 -> next cycle ex_val_rn=0x11, ex_val_rm=0x22, ex_cmd=0010, ex_wb_en=1, ex_dest=3.
- Load-use (FWD_EN=1): exe_mem_r=1, exe_wb_en=1, exe_dest=4, instr 0xE0845002 (ADD R5,R4,R2) -> hazard=1 and a bubble is loaded. Same case with exe_mem_r=0 -> hazard=0. With FWD_EN=0, mem_wb_en=1 and mem_dest=2 -> hazard=1.
- Load decode: instr 0xE5914008 (LDR R4,[R1,#8]) -> ex_mem_r=1, ex_wb_en=1, ex_cmd=0010, ex_shift_op=0x008. STR with Rd=4 -> ex_src2=4, ex_mem_w=1.
- Condition: instr 0x03A00001 (MOVEQ R0,#1) with status_in=0000 -> bubble. With Z=1 -> ex_cmd=0001, ex_imm=1, ex_wb_en=1.
- Freeze vs flush: assert freeze and flush together -> outputs hold the previous values. Release freeze with flush still high -> bubble loaded.
